muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Iterative multiply/divide unit for the RV32 datapath, implementing the M-extension operations that the single-cycle bit-slice ALU cannot (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU). It sits beside the ALU in the execute stage. It accepts operands on a start pulse and computes one bit per cycle using shift-add (multiply) or restoring shift-subtract (divide). It returns the result with a one-cycle done pulse while the control unit stalls the PC on busy_o.

## Interface
- WIDTH, 32, operand/result width in bits (even, ≥4)
- clk_i  input  1  single clock; all state updates on rising edge
- rst_i  input  1  synchronous, active-high reset
- start_i  input  1  request; sampled only in IDLE
- op_i  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a_i  input  WIDTH  rs1 operand (dividend / multiplicand)
- b_i  input  WIDTH  rs2 operand (divisor / multiplier)
- busy_o  output  1  high from the cycle after start is accepted through the DONE cycle inclusive
- done_o  output  1  one-cycle pulse; res_o valid in that cycle
- res_o  output  WIDTH  result; held from done_o until the next accepted start

## Operation
- States: IDLE → CALC → FIX → DONE → IDLE.
- IDLE:
  - start_i=1 registers op_i, a_i and b_i.
  - Signed ops (MUL, MULH, DIV, REM; MULHSU for a only) register operand magnitudes plus sign flags.
  - Loads iteration counter = WIDTH-1 and enters CALC. start_i=0 stays in IDLE.
- CALC, multiply: 2·WIDTH-bit product accumulator. Each cycle, if the multiplier LSB is 1, add the multiplicand to the upper half; then shift right 1 (unsigned magnitudes).
- CALC, divide: remainder register (WIDTH+1 bits) and quotient register. Each cycle, shift {rem,quo} left 1 and trial-subtract the divisor. If non-negative, keep the difference and set quo LSB=1; otherwise restore.
- CALC exit: counter decrements each cycle; at counter 0, go to FIX. CALC lasts exactly WIDTH cycles.
- FIX: apply signs, then select the result.
  - Product negated if sign(a)^sign(b).
  - Quotient negated if sign(a)^sign(b).
  - Remainder takes the sign of the dividend.
  - MUL returns the low half; MULH/MULHSU/MULHU return the high half. DIV/DIVU return the quotient; REM/REMU return the remainder. Result is registered into res_o.
- DONE: done_o=1, then IDLE.
- Divide by zero (b=0): quotient = all ones (DIV and DIVU); remainder = a. The restoring algorithm yields this naturally; the sign fix is suppressed when b=0.
- Signed overflow (DIV/REM, a=100…0, b=all ones): quotient = 100…0, remainder = 0. Forced in FIX.
- start_i while busy is ignored, with no queuing. Operand changes after acceptance have no effect.
- Reset (any state, including mid-CALC): state=IDLE, busy_o=0, done_o=0, res_o=0, all internal registers 0. An in-flight operation is discarded.

## Timing
- Reset values: busy_o=0, done_o=0, res_o=0.
- Start sampled at edge E0 → busy_o=1 after E0.
- CALC occupies edges E1..E(WIDTH); FIX completes at E(WIDTH+1); done_o=1 after E(WIDTH+1) for exactly one cycle.
- Latency: WIDTH+2 cycles from start to done, fixed for all ops including special cases. This is 34 cycles at WIDTH=32.
- busy_o falls together with done_o at E(WIDTH+2). A new start_i is accepted at the first edge where the state is IDLE, so back-to-back operations are spaced WIDTH+2 cycles apart.
- start_i asserted in the DONE cycle is ignored.

## Test plan
- MUL a=7, b=0xFFFFFFFD (−3) → done_o exactly 34 cycles after start; res_o=0xFFFFFFEB; busy_o high 34 cycles.
- MULH a=b=0x80000000 → 0x40000000. MULHU a=b=0xFFFFFFFF → 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF. DIVU a=100, b=7 → 14; REMU → 2.
- Divide by zero: DIVU a=0x1234, b=0 → 0xFFFFFFFF; REM a=0xFFFFFFF9, b=0 → 0xFFFFFFF9.
- Overflow: DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
- Control:
  - rst_i asserted at cycle 10 of a DIV → next cycle busy_o=0, done_o=0, res_o=0, and no done pulse follows.
  - start_i held high during busy with different operands → only the first result is produced.
  - New start is accepted on the cycle after done.

Source files
------------

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_seq
// Description : Iterative RV32 M-extension multiply/divide unit. One bit per
//               cycle: shift-add multiply, restoring shift-subtract divide.
//               Operands are converted to magnitudes on acceptance and signs
//               are reapplied in a single fix-up cycle.
// Ports       : clk_i    - clock, rising edge
//               rst_i    - synchronous active-high reset
//               start_i  - request, sampled only while idle
//               op_i     - funct3 (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU)
//               a_i      - rs1 (multiplicand / dividend)
//               b_i      - rs2 (multiplier / divisor)
//               busy_o   - high from the cycle after acceptance through done
//               done_o   - one-cycle pulse, res_o valid
//               res_o    - result, held until overwritten by the next op
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] res_o
);

    localparam int c_CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state_q, w_state_d;
    logic [2:0]           r_op_q, w_op_d;
    logic                 r_neg_a_q, w_neg_a_d;
    logic                 r_neg_b_q, w_neg_b_d;
    logic                 r_bzero_q, w_bzero_d;
    logic                 r_ovf_q, w_ovf_d;
    logic [c_CNT_W-1:0]   r_cnt_q, w_cnt_d;
    // Multiplicand magnitude (multiply) or divisor magnitude (divide)
    logic [WIDTH-1:0]     r_opnd_q, w_opnd_d;
    // Product accumulator: upper half sums, lower half holds the multiplier
    logic [2*WIDTH-1:0]   r_acc_q, w_acc_d;
    logic [WIDTH:0]       r_rem_q, w_rem_d;
    logic [WIDTH-1:0]     r_quo_q, w_quo_d;
    logic [WIDTH-1:0]     r_res_q, w_res_d;

    // Acceptance-time operand decode
    logic                 w_is_div;
    logic                 w_sgn_a;
    logic                 w_sgn_b;
    logic                 w_neg_a;
    logic                 w_neg_b;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;

    // Datapath
    logic [WIDTH:0]       w_sum;
    logic [WIDTH+1:0]     w_shift;
    logic [WIDTH+1:0]     w_diff;
    logic                 w_neg_res;
    logic [2*WIDTH-1:0]   w_prod_f;
    logic [WIDTH-1:0]     w_quo_f;
    logic [WIDTH-1:0]     w_rem_f;

    assign w_is_div = op_i[2];
    // Signed a: MUL, MULH, MULHSU, DIV, REM. Signed b: MUL, MULH, DIV, REM.
    assign w_sgn_a  = w_is_div ? ~op_i[0] : (op_i[1:0] != 2'b11);
    assign w_sgn_b  = w_is_div ? ~op_i[0] : ~op_i[1];
    assign w_neg_a  = w_sgn_a & a_i[WIDTH-1];
    assign w_neg_b  = w_sgn_b & b_i[WIDTH-1];
    assign w_mag_a  = w_neg_a ? -a_i : a_i;
    assign w_mag_b  = w_neg_b ? -b_i : b_i;

    // Multiply step: conditional add into the upper half, carry kept in bit WIDTH
    assign w_sum    = {1'b0, r_acc_q[2*WIDTH-1:WIDTH]}
                    + (r_acc_q[0] ? {1'b0, r_opnd_q} : {(WIDTH+1){1'b0}});

    // Divide step: the remainder stays below the divisor, so its top bit is
    // always zero and the trial difference sign lands in bit WIDTH+1.
    assign w_shift  = {r_rem_q, r_quo_q[WIDTH-1]};
    assign w_diff   = w_shift - {2'b00, r_opnd_q};

    assign w_neg_res = r_neg_a_q ^ r_neg_b_q;
    assign w_prod_f  = w_neg_res ? -r_acc_q : r_acc_q;

    // Divide by zero leaves the raw all-ones quotient unsigned; the remainder
    // already equals |a| and taking the dividend sign restores a exactly.
    always_comb begin
        w_quo_f = r_quo_q;
        w_rem_f = r_rem_q[WIDTH-1:0];
        if (r_bzero_q) begin
            w_quo_f = {WIDTH{1'b1}};
        end else if (r_ovf_q) begin
            w_quo_f = {1'b1, {(WIDTH-1){1'b0}}};
        end else if (w_neg_res) begin
            w_quo_f = -r_quo_q;
        end
        if (r_ovf_q) begin
            w_rem_f = {WIDTH{1'b0}};
        end else if (r_neg_a_q) begin
            w_rem_f = -r_rem_q[WIDTH-1:0];
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_op_d    = r_op_q;
        w_neg_a_d = r_neg_a_q;
        w_neg_b_d = r_neg_b_q;
        w_bzero_d = r_bzero_q;
        w_ovf_d   = r_ovf_q;
        w_cnt_d   = r_cnt_q;
        w_opnd_d  = r_opnd_q;
        w_acc_d   = r_acc_q;
        w_rem_d   = r_rem_q;
        w_quo_d   = r_quo_q;
        w_res_d   = r_res_q;

        case (r_state_q)
            S_IDLE: begin
                if (start_i) begin
                    w_op_d    = op_i;
                    w_neg_a_d = w_neg_a;
                    w_neg_b_d = w_neg_b;
                    w_bzero_d = (b_i == {WIDTH{1'b0}});
                    w_ovf_d   = w_is_div & ~op_i[0]
                              & (a_i == {1'b1, {(WIDTH-1){1'b0}}})
                              & (b_i == {WIDTH{1'b1}});
                    w_cnt_d   = c_CNT_W'(WIDTH - 1);
                    w_rem_d   = {(WIDTH+1){1'b0}};
                    if (w_is_div) begin
                        w_opnd_d = w_mag_b;
                        w_quo_d  = w_mag_a;
                        w_acc_d  = {(2*WIDTH){1'b0}};
                    end else begin
                        w_opnd_d = w_mag_a;
                        w_acc_d  = {{WIDTH{1'b0}}, w_mag_b};
                        w_quo_d  = {WIDTH{1'b0}};
                    end
                    w_state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (r_op_q[2]) begin
                    if (!w_diff[WIDTH+1]) begin
                        w_rem_d = w_diff[WIDTH:0];
                        w_quo_d = {r_quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        w_rem_d = w_shift[WIDTH:0];
                        w_quo_d = {r_quo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    w_acc_d = {w_sum, r_acc_q[WIDTH-1:1]};
                end
                w_cnt_d = r_cnt_q - 1'b1;
                if (r_cnt_q == {c_CNT_W{1'b0}}) begin
                    w_state_d = S_FIX;
                end
            end
            S_FIX: begin
                case (r_op_q)
                    3'b000:                 w_res_d = w_prod_f[WIDTH-1:0];
                    3'b001, 3'b010, 3'b011: w_res_d = w_prod_f[2*WIDTH-1:WIDTH];
                    3'b100, 3'b101:         w_res_d = w_quo_f;
                    default:                w_res_d = w_rem_f;
                endcase
                w_state_d = S_DONE;
            end
            S_DONE: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q <= S_IDLE;
            r_op_q    <= 3'b000;
            r_neg_a_q <= 1'b0;
            r_neg_b_q <= 1'b0;
            r_bzero_q <= 1'b0;
            r_ovf_q   <= 1'b0;
            r_cnt_q   <= {c_CNT_W{1'b0}};
            r_opnd_q  <= {WIDTH{1'b0}};
            r_acc_q   <= {(2*WIDTH){1'b0}};
            r_rem_q   <= {(WIDTH+1){1'b0}};
            r_quo_q   <= {WIDTH{1'b0}};
            r_res_q   <= {WIDTH{1'b0}};
        end else begin
            r_state_q <= w_state_d;
            r_op_q    <= w_op_d;
            r_neg_a_q <= w_neg_a_d;
            r_neg_b_q <= w_neg_b_d;
            r_bzero_q <= w_bzero_d;
            r_ovf_q   <= w_ovf_d;
            r_cnt_q   <= w_cnt_d;
            r_opnd_q  <= w_opnd_d;
            r_acc_q   <= w_acc_d;
            r_rem_q   <= w_rem_d;
            r_quo_q   <= w_quo_d;
            r_res_q   <= w_res_d;
        end
    end

    assign busy_o = (r_state_q != S_IDLE);
    assign done_o = (r_state_q == S_DONE);
    assign res_o  = r_res_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_seq
// Description : Directed self-checking bench for muldiv_seq (WIDTH=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;

    localparam int c_W = 32;

    logic           clk;
    logic           rst;
    logic           start;
    logic [2:0]     op;
    logic [c_W-1:0] a;
    logic [c_W-1:0] b;
    logic           busy;
    logic           done;
    logic [c_W-1:0] res;

    int checks = 0;
    int errors = 0;

    muldiv_seq #(.WIDTH(c_W)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .op_i    (op),
        .a_i     (a),
        .b_i     (b),
        .busy_o  (busy),
        .done_o  (done),
        .res_o   (res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one operation and check latency, busy length and result.
    // hold_start keeps start high with other operands for the whole run.
    // start_in_done raises start during the DONE cycle to confirm it is ignored.
    task automatic do_op(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] exp, input string tag,
                         input bit hold_start, input bit start_in_done);
        int cyc;
        int busy_cnt;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
        @(posedge clk);
        #1;
        start    = hold_start;
        op       = 3'b000;
        a        = ~va;
        b        = vb ^ 32'h5A5A_0001;
        cyc      = 1;
        busy_cnt = busy ? 1 : 0;
        while (!done && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            if (busy) busy_cnt++;
        end
        check({tag, " done"}, {31'd0, done}, 32'd1);
        check({tag, " latency"}, cyc, 32'd34);
        check({tag, " busy_len"}, busy_cnt, 32'd34);
        check({tag, " res"}, res, exp);
        start = start_in_done;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, " busy_after"}, {31'd0, busy}, 32'd0);
        check({tag, " done_after"}, {31'd0, done}, 32'd0);
        check({tag, " res_held"}, res, exp);
    endtask

    initial begin
        int seen;
        rst   = 1'b1;
        start = 1'b0;
        op    = 3'b000;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset res", res, 32'd0);
        rst = 1'b0;

        // Multiply
        do_op(3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, "MUL 7*-3", 0, 0);
        do_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "MULH min*min", 0, 0);
        do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "MULHU", 0, 0);
        do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHSU", 0, 0);
        do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "MULH -1*-1", 0, 0);
        do_op(3'b000, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, "MUL low", 0, 0);

        // Divide
        do_op(3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, "DIV -7/2", 0, 0);
        do_op(3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, "REM -7%2", 0, 0);
        do_op(3'b100, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, "DIV 7/-2", 0, 0);
        do_op(3'b110, 32'd7,        32'hFFFF_FFFE, 32'h0000_0001, "REM 7%-2", 0, 0);
        do_op(3'b101, 32'd100,      32'd7,         32'd14,        "DIVU 100/7", 0, 0);
        do_op(3'b111, 32'd100,      32'd7,         32'd2,         "REMU 100%7", 0, 0);

        // Divide by zero
        do_op(3'b101, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, "DIVU /0", 0, 0);
        do_op(3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, "REM /0", 0, 0);
        do_op(3'b100, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, "DIV neg/0", 0, 0);
        do_op(3'b111, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, "REMU /0", 0, 0);

        // Signed overflow
        do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "DIV ovf", 0, 0);
        do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "REM ovf", 0, 0);

        // start held through busy, and start raised in DONE cycle
        do_op(3'b101, 32'd1000, 32'd9, 32'd111, "DIVU held", 1, 0);
        do_op(3'b000, 32'd12,   32'd11, 32'd132, "MUL start_in_done", 0, 1);

        // Reset mid-operation
        @(negedge clk);
        start = 1'b1;
        op    = 3'b100;
        a     = 32'd500;
        b     = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst busy", {31'd0, busy}, 32'd0);
        check("midrst done", {31'd0, done}, 32'd0);
        check("midrst res", res, 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) seen = 1;
        end
        check("midrst no done", seen, 32'd0);

        // Unit still usable after reset
        do_op(3'b111, 32'd50, 32'd8, 32'd2, "REMU post_rst", 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
